// File: rtl/axis_dsp_stream_if_if.sv
// Bundle of the operand stream, dsp pipeline taps and result stream around axis_dsp_stream_if.
// The master modport is the stream block itself; slave is the surrounding environment.
interface axis_dsp_stream_if_if #(
  parameter int DATA_WIDTH = 16
);
  logic [4*DATA_WIDTH-1:0] s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;

  logic [DATA_WIDTH-1:0]   dsp_a;
  logic [DATA_WIDTH-1:0]   dsp_b;
  logic [DATA_WIDTH-1:0]   dsp_c;
  logic [DATA_WIDTH-1:0]   dsp_d;
  logic [DATA_WIDTH-1:0]   dsp_p;
  logic                    dsp_pd;

  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic                    m_axis_tuser;
  logic                    m_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  logic [15:0]             match_cnt;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, dsp_p, dsp_pd, m_axis_tready,
    output s_axis_tready, dsp_a, dsp_b, dsp_c, dsp_d,
           m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid, match_cnt
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, dsp_p, dsp_pd, m_axis_tready,
    input  s_axis_tready, dsp_a, dsp_b, dsp_c, dsp_d,
           m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid, match_cnt
  );
endinterface

// File: rtl/axis_dsp_stream_if.sv
// AXI-Stream wrapper for the 3-stage dsp multiply-compare pipeline: skews operands,
// tags issues through the pipe, buffers results in a credit-protected FIFO and packetises them.
module axis_dsp_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                clk,
  input  logic                rst,
  axis_dsp_stream_if_if.master bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  typedef struct packed {
    logic                  pd;
    logic [DATA_WIDTH-1:0] p;
  } result_t;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [1:0]            in_flight;
  logic [CNT_W:0]        credit_used;
  logic [DATA_WIDTH-1:0] op_a, op_b, op_c, op_d;
  result_t               head;

  logic [DATA_WIDTH-1:0] b_q, c1_q, c2_q;
  logic [2:0]            vld_q;
  result_t               mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [15:0]           match_q, match_d;

  assign {op_c, op_b, op_d, op_a} = bus.s_axis_tdata;

  // Every tagged beat already owns a FIFO slot, so the push side can never overrun.
  assign in_flight   = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};
  assign credit_used = {1'b0, fifo_count_q} + {{(CNT_W-1){1'b0}}, in_flight};

  assign bus.s_axis_tready = !rst && (credit_used < {1'b0, DEPTH_C});
  assign issue             = bus.s_axis_tvalid & bus.s_axis_tready;

  // a/d feed the first pipe stage this cycle; b and c follow one and two edges later.
  assign bus.dsp_a = issue ? op_a : '0;
  assign bus.dsp_d = issue ? op_d : '0;
  assign bus.dsp_b = b_q;
  assign bus.dsp_c = c2_q;

  assign push = vld_q[2];
  assign pop  = bus.m_axis_tvalid & bus.m_axis_tready;
  assign head = mem_q[rd_ptr_q];

  assign bus.m_axis_tvalid = (fifo_count_q != '0);
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? head.p  : '0;
  assign bus.m_axis_tuser  = bus.m_axis_tvalid ? head.pd : 1'b0;
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && (beat_q == LAST_BEAT);
  assign bus.match_cnt     = match_q;

  always_comb begin
    // NOTE: every combinational output is given a default before any branch, so no latch is inferred.
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    fifo_count_d = fifo_count_q;
    beat_d       = beat_q;
    match_d      = match_q;

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase

    if (pop) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      if (head.pd && (match_q != 16'hFFFF)) begin
        match_d = match_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (rst) begin
      b_q          <= '0;
      c1_q         <= '0;
      c2_q         <= '0;
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      beat_q       <= '0;
      match_q      <= '0;
    end else begin
      b_q          <= issue ? op_b : '0;
      c1_q         <= issue ? op_c : '0;
      c2_q         <= c1_q;
      vld_q        <= {vld_q[1:0], issue};
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      beat_q       <= beat_d;
      match_q      <= match_d;
    end
  end

  // NOTE: the result storage is deliberately not reset; an entry is only visible once the count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pd: bus.dsp_pd, p: bus.dsp_p};
    end
  end
endmodule

// File: tb/tb_axis_dsp_stream_if.sv
// Self-checking bench for axis_dsp_stream_if with a behavioural dsp pipeline attached and
// a queue-based reference model of the result stream.
module tb_axis_dsp_stream_if;
  localparam int DW         = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int PKT_LEN    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_dsp_stream_if_if #(.DATA_WIDTH(DW)) bus ();

  axis_dsp_stream_if #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // The attached pipeline: pre-add a+d, multiply by b, then compare the product with c.
  logic [DW-1:0] ad_q, m_q;
  always @(posedge clk) begin
    ad_q       <= bus.dsp_a + bus.dsp_d;
    m_q        <= ad_q * bus.dsp_b;
    bus.dsp_p  <= m_q;
    bus.dsp_pd <= (m_q == bus.dsp_c);
  end

  int ovf = 0;
  always @(negedge clk) begin
    if (!rst && dut.vld_q[2] && (dut.fifo_count_q == 4'(FIFO_DEPTH))) ovf++;
  end

  int errors = 0;
  int checks = 0;

  logic [16:0] exp_q[$];
  logic [17:0] obs_q[$];
  int          out_beat;
  int          model_match;
  int          issued;
  bit          stalled;
  bit          s_acc;
  logic [17:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack(input int a, input int d, input int b, input int c);
    return {16'(c), 16'(b), 16'(d), 16'(a)};
  endfunction

  function automatic logic [16:0] ref_result(input logic [63:0] beat);
    longint unsigned a, d, b, c, p;
    a = beat[15:0];
    d = beat[31:16];
    b = beat[47:32];
    c = beat[63:48];
    p = ((a + d) * b) % 65536;
    return {p == c, 16'(p)};
  endfunction

  function automatic logic [63:0] rand_beat();
    int a, d, b, c;
    a = int'($urandom_range(0, 65535));
    d = int'($urandom_range(0, 65535));
    b = int'($urandom_range(0, 65535));
    c = ($urandom_range(0, 1) == 1) ? ((a + d) * b) % 65536 : int'($urandom_range(0, 65535));
    return pack(a, d, b, c);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    obs_q.delete();
    out_beat    = 0;
    model_match = 0;
    issued      = 0;
    stalled     = 1'b0;
    s_acc       = 1'b0;
  endtask

  task automatic monitor();
    logic [17:0] cur;
    logic [16:0] e;
    cur   = {bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata};
    s_acc = 1'b0;
    if (rst) begin
      stalled = 1'b0;
      return;
    end
    if (stalled) check("stall_hold", 32'(cur), 32'(held));
    if (bus.s_axis_tvalid && bus.s_axis_tready) begin
      exp_q.push_back(ref_result(bus.s_axis_tdata));
      issued++;
      s_acc = 1'b1;
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      obs_q.push_back(cur);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(bus.m_axis_tvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tdata", 32'(cur[15:0]), 32'(e[15:0]));
        check("tuser", 32'(cur[16]), 32'(e[16]));
        check("tlast", 32'(cur[17]), 32'(out_beat == PKT_LEN - 1));
        out_beat = (out_beat + 1) % PKT_LEN;
        if (e[16] && model_match < 65535) model_match++;
      end
    end
    stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
    held    = cur;
  endtask

  task automatic at_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    at_neg();
    to_pos();
  endtask

  task automatic reset_dut();
    rst               = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    clear_model();
    at_neg();
    to_pos();
    rst = 1'b0;
  endtask

  int exp_p[4] = '{2, 4, 21, 0};
  int exp_u[4] = '{1, 0, 1, 1};
  int opnd[4][4] = '{'{1, 1, 1, 2}, '{1, 1, 2, 5}, '{0, 7, 3, 21}, '{65535, 1, 5, 0}};

  initial begin
    int vcnt;
    logic [3:0] lasts;

    rst               = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;
    clear_model();

    // Reset state
    at_neg();
    check("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
    check("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_m_tlast",  32'(bus.m_axis_tlast),  32'd0);
    check("rst_m_tdata",  32'(bus.m_axis_tdata),  32'd0);
    check("rst_m_tuser",  32'(bus.m_axis_tuser),  32'd0);
    check("rst_dsp_abcd", 32'({bus.dsp_a, bus.dsp_b} | {bus.dsp_c, bus.dsp_d}), 32'd0);
    check("rst_match",    32'(bus.match_cnt), 32'd0);
    to_pos();
    rst = 1'b0;
    at_neg();
    check("ready_after_release", 32'(bus.s_axis_tready), 32'd1);
    to_pos();

    // Single beat: operand skew and 4-cycle latency
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = pack(2, 3, 4, 20);
    at_neg();
    check("t0_dsp_a", 32'(bus.dsp_a), 32'd2);
    check("t0_dsp_d", 32'(bus.dsp_d), 32'd3);
    to_pos();
    bus.s_axis_tvalid = 1'b0;
    at_neg();
    check("t1_dsp_b", 32'(bus.dsp_b), 32'd4);
    check("t1_dsp_a_idle", 32'(bus.dsp_a), 32'd0);
    to_pos();
    at_neg();
    check("t2_dsp_c", 32'(bus.dsp_c), 32'd20);
    to_pos();
    at_neg();
    check("t3_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    to_pos();
    at_neg();
    check("t4_m_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    check("t4_m_tdata",  32'(bus.m_axis_tdata),  32'd20);
    check("t4_m_tuser",  32'(bus.m_axis_tuser),  32'd1);
    to_pos();
    repeat (3) tick();

    // Four back-to-back beats forming one packet
    reset_dut();
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = pack(opnd[i][0], opnd[i][1], opnd[i][2], opnd[i][3]);
      tick();
    end
    bus.s_axis_tvalid = 1'b0;
    repeat (8) tick();
    check("b2b_count", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_tdata", 32'(obs_q[i][15:0]), 32'(exp_p[i]));
        check("b2b_tuser", 32'(obs_q[i][16]), 32'(exp_u[i]));
        check("b2b_tlast", 32'(obs_q[i][17]), 32'(i == 3));
      end
    end
    check("b2b_match_cnt", 32'(bus.match_cnt), 32'd3);

    // Backpressure: downstream stalled, source always valid
    reset_dut();
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.s_axis_tdata = rand_beat();
      tick();
    end
    check("bp_issued", 32'(issued), 32'(FIFO_DEPTH));
    at_neg();
    check("bp_ready_low", 32'(bus.s_axis_tready), 32'd0);
    check("bp_tvalid",    32'(bus.m_axis_tvalid), 32'd1);
    to_pos();
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    at_neg();
    check("bp_ready_during_pop", 32'(bus.s_axis_tready), 32'd0);
    to_pos();
    bus.m_axis_tready = 1'b0;
    at_neg();
    check("bp_ready_reopen", 32'(bus.s_axis_tready), 32'd1);
    to_pos();
    bus.m_axis_tready = 1'b1;
    repeat (12) tick();
    check("bp_drained", 32'(obs_q.size()), 32'(FIFO_DEPTH));
    check("bp_model_empty", 32'(exp_q.size()), 32'd0);

    // Alternating downstream ready with random operands
    reset_dut();
    for (int i = 0; i < 60; i++) begin
      bus.m_axis_tready = (i % 2 == 0);
      if (!bus.s_axis_tvalid || s_acc) begin
        bus.s_axis_tvalid = ($urandom_range(0, 3) != 0);
        bus.s_axis_tdata  = rand_beat();
      end
      tick();
    end
    bus.s_axis_tvalid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.m_axis_tready = (i % 2 == 0);
      tick();
    end
    check("alt_model_empty", 32'(exp_q.size()), 32'd0);
    check("alt_match_cnt", 32'(bus.match_cnt), 32'(model_match));

    // Reset with 2 tags in flight and 3 results buffered
    reset_dut();
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = rand_beat();
      tick();
    end
    bus.s_axis_tvalid = 1'b0;
    tick();
    at_neg();
    check("mr_pre_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    rst = 1'b1;
    clear_model();
    #1;
    check("mr_async_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("mr_async_ready",  32'(bus.s_axis_tready), 32'd0);
    to_pos();
    at_neg();
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      if (bus.m_axis_tvalid) vcnt++;
      to_pos();
    end
    check("mr_no_stale", 32'(vcnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = rand_beat();
      tick();
    end
    bus.s_axis_tvalid = 1'b0;
    repeat (8) tick();
    check("mr_count", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) begin
      lasts = {obs_q[3][17], obs_q[2][17], obs_q[1][17], obs_q[0][17]};
      check("mr_tlast_pattern", 32'(lasts), 32'b1000);
    end

    // match_cnt saturation
    reset_dut();
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = pack(0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) tick();
    bus.s_axis_tvalid = 1'b0;
    repeat (8) tick();
    check("sat_issued", 32'(issued), 32'd65540);
    check("sat_match_cnt", 32'(bus.match_cnt), 32'hFFFF);
    check("sat_model", 32'(bus.match_cnt), 32'(model_match));

    check("no_overflow", 32'(ovf), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
